chrono_ctrl: RTL
================

// Module: chrono_ctrl
// PURPOSE
//  Control sequencer for the digital stopwatch datapath (divider / BCD counter / display mux).
//  Turns three raw push-buttons and a mode switch into the counter's enable, upDown and clear.
//  Supports lap-freeze: latches a display snapshot while counting continues. Raises an alarm
//  and halts at terminal count. Sits between board I/O and the counter/display blocks.
// PARAMETERS
//  DEB_CYCLES   500000  clk cycles a synchronized button must be stable to be accepted (5 ms @100 MHz)
//  DEB_W        19      width of debounce counter, >= clog2(DEB_CYCLES+1)
//  ALARM_TICKS  6       tick periods the alarm stays active in DONE
// PORTS
//  clk       in   1  system clock, single clock domain
//  rst       in   1  asynchronous, active-low reset
//  btnStart  in   1  raw start/stop button, asynchronous, active-high
//  btnLap    in   1  raw lap button, asynchronous, active-high
//  btnClr    in   1  raw clear button, asynchronous, active-high
//  modeDown  in   1  mode switch, 1 = count down, 0 = count up
//  tick      in   1  1-cycle clock-enable pulse, 1 Hz, from the divider
//  cntZ      in   4  counter tens digit, BCD
//  cntU      in   4  counter units digit, BCD
//  enable    out  1  counter enable
//  upDown    out  1  counter direction, 1 = up
//  clrCnt    out  1  1-cycle synchronous clear pulse to the counter
//  freeze    out  1  1 = display shows lapZ/lapU instead of the live count
//  lapZ      out  4  latched tens digit
//  lapU      out  4  latched units digit
//  alarm     out  1  blinking alarm output
//  state     out  3  current FSM state encoding
// BEHAVIOUR
//  Reset: state=IDLE, enable=0, upDown=1, clrCnt=0, freeze=0, lapZ=lapU=0, alarm=0.
//   Reset clears the debounce logic. Reset mid-run aborts immediately with no clrCnt pulse.
//  Input path, per button: 2-flop synchronizer, then debounce.
//   The debounce counter restarts on any change of the synchronized level.
//   The level is accepted after DEB_CYCLES stable cycles.
//   A 0->1 edge of the accepted level gives a 1-cycle press pulse: input edge to pulse
//   latency = 2 + DEB_CYCLES + 1 cycles. Held buttons give exactly one pulse.
//  Same-cycle press priority: clr > start > lap. Lower-priority presses in that cycle are dropped.
//  Terminal count: cnt==00 when upDown=0; cnt==99 when upDown=1.
//  All outputs are registered. FSM reacts in the cycle after the press pulse.
//  States (state encoding): IDLE=0, RUN=1, PAUSE=2, LAP=3, DONE=4.
//   IDLE:  upDown <= ~modeDown every cycle.
//          start -> RUN, except when already at terminal count for the selected mode (then ignored).
//          clr -> clrCnt pulse, lap regs <= 0, stay IDLE. lap ignored.
//   RUN:   enable=1. lap -> latch cntZ/cntU, freeze=1, go LAP. start -> PAUSE.
//          clr ignored. Terminal count seen -> DONE. Terminal count beats start in the same cycle.
//   LAP:   enable=1, freeze=1. lap -> freeze=0, RUN. start -> freeze=0, PAUSE.
//          Terminal count -> DONE, freeze=0. clr ignored.
//   PAUSE: enable=0. upDown <= ~modeDown. start -> RUN, or ignored if at terminal count.
//          clr -> clrCnt, lap regs <= 0, IDLE.
//   DONE:  enable=0. alarm toggles on each tick, starting at 1 on entry.
//          After ALARM_TICKS ticks: alarm=0, go IDLE, no clear.
//          clr or start -> alarm=0, IDLE. clr also pulses clrCnt.
//  upDown changes only in IDLE or PAUSE, never while enable=1.
//  Terminal count is detected from cntZ/cntU with 1 cycle latency, so enable falls long
//   before the next tick and the counter never wraps.
//  enable falls the cycle after terminal detect. clrCnt is high exactly 1 cycle per accepted clr.
// TESTING (bench uses DEB_CYCLES=4, ALARM_TICKS=4, counter model on tick)
//  1. Bounce btnStart 3x (2-cycle glitches), then hold 10 cycles -> exactly one press;
//     enable=1 at input edge + 8 cycles; state=1.
//  2. Up mode from 00, run 12 ticks, press lap -> lapZ=1, lapU=2, freeze=1.
//     Live count reaches 15; press lap again -> freeze=0, state=1.
//  3. Down mode from 03, start -> at cnt=00 state=4 and enable=0 before the next tick.
//     alarm toggles 4 ticks, then state=0, alarm=0.
//  4. Start and clr pulses in the same cycle while PAUSE -> clrCnt=1 for 1 cycle, state=0;
//     the start press is dropped.
//  5. In RUN, toggle modeDown -> upDown unchanged. Press start (PAUSE) -> upDown follows
//     ~modeDown next cycle.
//  6. Assert rst low mid-LAP -> all outputs at reset values asynchronously.
//     Down mode at 00 plus start -> stays IDLE.

Source files
------------

// File: rtl/chrono_ctrl_if.sv
// Counter-side bus of the stopwatch sequencer: divider tick and BCD count in,
// enable/direction/clear out.
interface chrono_ctrl_if;
  logic       tick;
  logic [3:0] cntZ;
  logic [3:0] cntU;
  logic       enable;
  logic       upDown;
  logic       clrCnt;

  modport master (
    input  tick,
    input  cntZ,
    input  cntU,
    output enable,
    output upDown,
    output clrCnt
  );

  modport slave (
    output tick,
    output cntZ,
    output cntU,
    input  enable,
    input  upDown,
    input  clrCnt
  );
endinterface

// File: rtl/chrono_ctrl.sv
// Stopwatch control sequencer: debounces start/lap/clear buttons and drives the counter's
// enable, direction and clear, plus lap-freeze snapshot and terminal-count alarm.
module chrono_ctrl #(
  parameter int unsigned DEB_CYCLES  = 500000,
  parameter int unsigned DEB_W       = 19,
  parameter int unsigned ALARM_TICKS = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btnStart,
  input  logic          btnLap,
  input  logic          btnClr,
  input  logic          modeDown,
  chrono_ctrl_if.master ctr,
  output logic          freeze,
  output logic [3:0]    lapZ,
  output logic [3:0]    lapU,
  output logic          alarm,
  output logic [2:0]    state
);

  localparam int unsigned AlarmW = $clog2(ALARM_TICKS + 1);
  localparam logic [DEB_W-1:0]  DebLast   = DEB_W'(DEB_CYCLES - 1);
  localparam logic [AlarmW-1:0] AlarmLast = AlarmW'(ALARM_TICKS - 1);

  typedef enum logic [2:0] {
    Idle  = 3'd0,
    Run   = 3'd1,
    Pause = 3'd2,
    Lap   = 3'd3,
    Done  = 3'd4
  } stateE;

  // Button index: 0 = start, 1 = lap, 2 = clear.
  logic [2:0]       btnRaw;
  logic [2:0]       sync1Q, sync2Q, accQ, accPrevQ, pressQ;
  logic [DEB_W-1:0] debCntQ [3];

  assign btnRaw = {btnClr, btnLap, btnStart};

  // Counter runs only while the synchronized level differs from the accepted one,
  // so any bounce back to the accepted level restarts the stability window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1Q   <= '0;
      sync2Q   <= '0;
      accQ     <= '0;
      accPrevQ <= '0;
      pressQ   <= '0;
      for (int i = 0; i < 3; i++) debCntQ[i] <= '0;
    end else begin
      sync1Q   <= btnRaw;
      sync2Q   <= sync1Q;
      accPrevQ <= accQ;
      pressQ   <= accQ & ~accPrevQ;
      for (int i = 0; i < 3; i++) begin
        if (sync2Q[i] == accQ[i]) begin
          debCntQ[i] <= '0;
        end else if (debCntQ[i] == DebLast) begin
          accQ[i]    <= sync2Q[i];
          debCntQ[i] <= '0;
        end else begin
          debCntQ[i] <= debCntQ[i] + 1'b1;
        end
      end
    end
  end

  stateE             stateQ, stateD;
  logic              enableQ, enableD, upDownQ, upDownD, clrCntQ, clrCntD;
  logic              freezeQ, freezeD, alarmQ, alarmD, termQ;
  logic [3:0]        lapZQ, lapZD, lapUQ, lapUD;
  logic [AlarmW-1:0] alarmCntQ, alarmCntD;
  logic              clrP, startP, lapP;

  assign clrP   = pressQ[2];
  assign startP = pressQ[0] & ~pressQ[2];
  assign lapP   = pressQ[1] & ~pressQ[2] & ~pressQ[0];

  always_comb begin
    stateD    = stateQ;
    upDownD   = upDownQ;
    clrCntD   = 1'b0;
    lapZD     = lapZQ;
    lapUD     = lapUQ;
    alarmD    = alarmQ;
    alarmCntD = alarmCntQ;
    case (stateQ)
      Idle: begin
        upDownD = ~modeDown;
        if (clrP) begin
          clrCntD = 1'b1;
          lapZD   = '0;
          lapUD   = '0;
        end else if (startP && !termQ) begin
          stateD = Run;
        end
      end
      Run: begin
        if (termQ) begin
          stateD = Done;
        end else if (startP) begin
          stateD = Pause;
        end else if (lapP) begin
          stateD = Lap;
          lapZD  = ctr.cntZ;
          lapUD  = ctr.cntU;
        end
      end
      Lap: begin
        if (termQ)       stateD = Done;
        else if (startP) stateD = Pause;
        else if (lapP)   stateD = Run;
      end
      Pause: begin
        upDownD = ~modeDown;
        if (clrP) begin
          clrCntD = 1'b1;
          lapZD   = '0;
          lapUD   = '0;
          stateD  = Idle;
        end else if (startP && !termQ) begin
          stateD = Run;
        end
      end
      Done: begin
        if (clrP || startP) begin
          clrCntD = clrP;
          alarmD  = 1'b0;
          stateD  = Idle;
        end else if (ctr.tick) begin
          if (alarmCntQ == AlarmLast) begin
            alarmD = 1'b0;
            stateD = Idle;
          end else begin
            alarmD    = ~alarmQ;
            alarmCntD = alarmCntQ + 1'b1;
          end
        end
      end
      default: stateD = Idle;
    endcase
    if (stateD == Done && stateQ != Done) begin
      alarmD    = 1'b1;
      alarmCntD = '0;
    end
    enableD = (stateD == Run) || (stateD == Lap);
    freezeD = (stateD == Lap);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ    <= Idle;
      enableQ   <= 1'b0;
      upDownQ   <= 1'b1;
      clrCntQ   <= 1'b0;
      freezeQ   <= 1'b0;
      lapZQ     <= '0;
      lapUQ     <= '0;
      alarmQ    <= 1'b0;
      alarmCntQ <= '0;
      termQ     <= 1'b0;
    end else begin
      stateQ    <= stateD;
      enableQ   <= enableD;
      upDownQ   <= upDownD;
      clrCntQ   <= clrCntD;
      freezeQ   <= freezeD;
      lapZQ     <= lapZD;
      lapUQ     <= lapUD;
      alarmQ    <= alarmD;
      alarmCntQ <= alarmCntD;
      termQ     <= upDownQ ? (ctr.cntZ == 4'd9 && ctr.cntU == 4'd9)
                           : (ctr.cntZ == 4'd0 && ctr.cntU == 4'd0);
    end
  end

  assign ctr.enable = enableQ;
  assign ctr.upDown = upDownQ;
  assign ctr.clrCnt = clrCntQ;
  assign freeze     = freezeQ;
  assign lapZ       = lapZQ;
  assign lapU       = lapUQ;
  assign alarm      = alarmQ;
  assign state      = stateQ;

endmodule
